micron_sram_burst: RTL and testbench

- Parametrised, cycle-accurate simulation model of a Micron-style pseudo-SRAM in synchronous burst mode.
- Successor to the fixed-latency burst model. Adds:
  - a programmable bus configuration register (BCR) written through mcre;
  - selectable latency, burst length and wrap mode;
  - byte-lane write masking via ub_L/lb_L;
  - clean burst termination.
- Sits on the memory-controller testbench side as the external-memory device.

---
 rtl/micron_sram_burst_pkg.sv | 67 ++++++
 rtl/micron_sram_burst_count_reg.sv | 41 ++++
 rtl/micron_sram_burst.sv | 201 ++++++++++++++++++++
 tb/tb_micron_sram_burst.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/micron_sram_burst_pkg.sv
// Shared definitions for the micron_sram_burst pseudo-SRAM model:
// FSM state encoding, BCR layout and field positions, burst-length codes,
// active-level constants and small decode helpers.
package micron_sram_burst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CFG     = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_WR_DATA = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // BCR field positions within addr when mcre=1
    localparam int unsigned LAT_MSB  = 13;
    localparam int unsigned LAT_LSB  = 11;
    localparam int unsigned WRAP_BIT = 3;
    localparam int unsigned BL_MSB   = 2;
    localparam int unsigned BL_LSB   = 0;

    localparam logic [2:0] BL_CODE_4    = 3'd1;
    localparam logic [2:0] BL_CODE_8    = 3'd2;
    localparam logic [2:0] BL_CODE_16   = 3'd3;
    localparam logic [2:0] BL_CODE_CONT = 3'd7;

    localparam logic [2:0] LAT_MIN = 3'd2;
    localparam logic [2:0] LAT_MAX = 3'd6;

    localparam logic ASSERT   = 1'b1;
    localparam logic ASSERT_L = 1'b0;

    // Beat counter must hold BL-1 for the longest fixed burst (16)
    localparam int unsigned BEAT_W = 5;
    localparam int unsigned WAIT_W = 3;

    // Bus configuration register: nowrap=1 means linear bursts
    typedef struct packed {
        logic [2:0] lat;
        logic       nowrap;
        logic [2:0] bl_code;
    } bcr_t;

    function automatic logic lat_legal(input logic [2:0] lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

    function automatic logic bl_legal(input logic [2:0] code);
        return (code == BL_CODE_4) || (code == BL_CODE_8) ||
               (code == BL_CODE_16) || (code == BL_CODE_CONT);
    endfunction

    // BL-1 for fixed burst codes; doubles as the wrap mask and last-beat index
    function automatic logic [3:0] bl_last(input logic [2:0] code);
        logic [3:0] m;
        m = 4'd0;
        case (code)
            BL_CODE_4:  m = 4'd3;
            BL_CODE_8:  m = 4'd7;
            BL_CODE_16: m = 4'd15;
            default:    m = 4'd0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/micron_sram_burst_count_reg.sv
// Generic loadable up-counter shared by the address, wait and beat counters.
// Ports: clk, reset_L (sync, active low), clr / load / inc controls with
// priority clr > load > inc, load_val, cnt (registered count).
module micron_sram_burst_count_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    // Next count selection
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/micron_sram_burst.sv
// Cycle-accurate model of a Micron-style pseudo-SRAM in synchronous burst mode
// with a programmable BCR (latency, burst length, wrap), byte-lane write masks
// and burst termination on ce_L deassertion.
// Ports: clk, reset_L (sync, active low); addr (burst address or BCR data);
// adv_L, ce_L, oe_L, we_L, ub_L, lb_L, mcre controls; mem_wait (latency
// indicator); data (bidirectional, Z when not driving).
module micron_sram_burst
    import micron_sram_burst_pkg::*;
#(
    parameter int unsigned D_WIDTH     = 16,
    parameter int unsigned A_WIDTH     = 16,
    parameter int unsigned DEPTH       = 2**A_WIDTH,
    parameter int unsigned RST_LATENCY = 4,
    parameter logic [2:0]  RST_BL_CODE = 3'd7,
    parameter logic        RST_NOWRAP  = 1'b1
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic [A_WIDTH-1:0] addr,
    input  logic               adv_L,
    input  logic               ce_L,
    input  logic               oe_L,
    input  logic               we_L,
    input  logic               ub_L,
    input  logic               lb_L,
    input  logic               mcre,
    output logic               mem_wait,
    inout  wire  [D_WIDTH-1:0] data
);

    localparam int unsigned BYTE_W = 8;
    localparam bcr_t BCR_RST = '{lat: 3'(RST_LATENCY), nowrap: RST_NOWRAP, bl_code: RST_BL_CODE};

    state_t state_q, state_d;
    bcr_t   bcr_q, bcr_d;
    logic   mem_wait_q, mem_wait_d;

    logic [A_WIDTH-1:0] cur_addr;
    logic [A_WIDTH-1:0] next_addr;
    logic [A_WIDTH-1:0] addr_load_val;
    logic               addr_load;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               wait_clr;
    logic               wait_inc;
    logic [BEAT_W-1:0]  beat_cnt;
    logic               beat_clr;
    logic               beat_inc;
    logic               wr_en;
    logic [3:0]         wrap_mask;
    logic               rd_drive_c;

    logic [D_WIDTH-1:0] mem [DEPTH];

    micron_sram_burst_count_reg #(.WIDTH(A_WIDTH)) u_addr_cnt (
        .clk      (clk),
        .reset_L  (reset_L),
        .clr      (1'b0),
        .load     (addr_load),
        .load_val (addr_load_val),
        .inc      (1'b0),
        .cnt      (cur_addr)
    );

    micron_sram_burst_count_reg #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clk      (clk),
        .reset_L  (reset_L),
        .clr      (wait_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (wait_inc),
        .cnt      (wait_cnt)
    );

    micron_sram_burst_count_reg #(.WIDTH(BEAT_W)) u_beat_cnt (
        .clk      (clk),
        .reset_L  (reset_L),
        .clr      (beat_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (beat_inc),
        .cnt      (beat_cnt)
    );

    // Next beat address: linear with top-of-memory rollover, or wrap inside BL
    always_comb begin
        wrap_mask = bl_last(bcr_q.bl_code);
        if (cur_addr == A_WIDTH'(DEPTH - 1)) begin
            next_addr = '0;
        end else begin
            next_addr = cur_addr + A_WIDTH'(1);
        end
        if (!bcr_q.nowrap && (bcr_q.bl_code != BL_CODE_CONT)) begin
            next_addr = (cur_addr & ~A_WIDTH'(wrap_mask)) |
                        ((cur_addr + A_WIDTH'(1)) & A_WIDTH'(wrap_mask));
        end
    end

    // Next-state, BCR update and counter controls
    always_comb begin
        state_d       = state_q;
        bcr_d         = bcr_q;
        addr_load     = 1'b0;
        addr_load_val = next_addr;
        wait_clr      = 1'b0;
        wait_inc      = 1'b0;
        beat_clr      = 1'b0;
        beat_inc      = 1'b0;
        wr_en         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((ce_L == ASSERT_L) && (adv_L == ASSERT_L)) begin
                    if (mcre == ASSERT) begin
                        if (we_L == ASSERT_L) begin
                            state_d      = ST_CFG;
                            bcr_d.nowrap = addr[WRAP_BIT];
                            if (lat_legal(addr[LAT_MSB:LAT_LSB])) begin
                                bcr_d.lat = addr[LAT_MSB:LAT_LSB];
                            end
                            if (bl_legal(addr[BL_MSB:BL_LSB])) begin
                                bcr_d.bl_code = addr[BL_MSB:BL_LSB];
                            end
                        end
                    end else begin
                        addr_load     = 1'b1;
                        addr_load_val = addr;
                        wait_clr      = 1'b1;
                        beat_clr      = 1'b1;
                        state_d       = (we_L == ASSERT_L) ? ST_WR_WAIT : ST_RD_WAIT;
                    end
                end
            end
            ST_CFG: begin
                state_d = ST_IDLE;
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                // Leaving at count LAT-2 gives LAT-1 cycles of mem_wait
                if (wait_cnt == (bcr_q.lat - 3'd2)) begin
                    state_d = (state_q == ST_WR_WAIT) ? ST_WR_DATA : ST_RD_DATA;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_RD_DATA, ST_WR_DATA: begin
                beat_inc  = 1'b1;
                addr_load = 1'b1;
                wr_en     = (state_q == ST_WR_DATA);
                if ((bcr_q.bl_code != BL_CODE_CONT) &&
                    (beat_cnt == BEAT_W'(bl_last(bcr_q.bl_code)))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Chip deselect aborts any activity; the write on this edge is dropped
        if ((state_q != ST_IDLE) && (ce_L != ASSERT_L)) begin
            state_d   = ST_IDLE;
            wr_en     = 1'b0;
            addr_load = 1'b0;
            wait_inc  = 1'b0;
            beat_inc  = 1'b0;
        end

        mem_wait_d = (state_d == ST_RD_WAIT) || (state_d == ST_WR_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q    <= ST_IDLE;
            bcr_q      <= BCR_RST;
            mem_wait_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcr_q      <= bcr_d;
            mem_wait_q <= mem_wait_d;
        end
    end

    // Memory array keeps its contents through reset
    always_ff @(posedge clk) begin
        if (reset_L && wr_en) begin
            if (ub_L == ASSERT_L) begin
                mem[cur_addr][D_WIDTH-1:BYTE_W] <= data[D_WIDTH-1:BYTE_W];
            end
            if (lb_L == ASSERT_L) begin
                mem[cur_addr][BYTE_W-1:0] <= data[BYTE_W-1:0];
            end
        end
    end

    assign rd_drive_c = (state_q == ST_RD_DATA) && (ce_L == ASSERT_L) && (oe_L == ASSERT_L);
    assign data       = rd_drive_c ? mem[cur_addr] : {D_WIDTH{1'bz}};
    assign mem_wait   = mem_wait_q;

endmodule

// File: tb/tb_micron_sram_burst.sv
// Self-checking bench for micron_sram_burst: directed scenarios plus randomized
// BCR/burst sweeps checked against a word-level memory and burst-address model.
module tb_micron_sram_burst;

    logic        clk = 1'b0;
    logic        reset_L;
    logic [15:0] addr;
    logic        adv_L, ce_L, oe_L, we_L, ub_L, lb_L, mcre;
    wire         mem_wait;
    wire  [15:0] data;
    logic [15:0] tb_dq;
    logic        tb_drv;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_lat;
    int          m_nowrap;
    int          m_bl;
    logic [15:0] mm [int];
    logic [15:0] bw_data [16];
    logic [1:0]  bw_mask [16];
    logic [15:0] z16;

    always #5 clk = ~clk;

    assign data = tb_drv ? tb_dq : 16'hzzzz;

    micron_sram_burst dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .addr     (addr),
        .adv_L    (adv_L),
        .ce_L     (ce_L),
        .oe_L     (oe_L),
        .we_L     (we_L),
        .ub_L     (ub_L),
        .lb_L     (lb_L),
        .mcre     (mcre),
        .mem_wait (mem_wait),
        .data     (data)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int bl_len(input int code);
        case (code)
            1:       return 4;
            2:       return 8;
            3:       return 16;
            default: return 0;
        endcase
    endfunction

    // Address of beat i of a burst starting at start, under the current BCR
    function automatic int beat_addr(input int start, input int i);
        int n;
        n = bl_len(m_bl);
        if (n == 0 || m_nowrap != 0) return (start + i) % 65536;
        return (start - (start % n)) + (((start % n) + i) % n);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        ce_L = 1'b1; adv_L = 1'b1; we_L = 1'b1; mcre = 1'b0;
        oe_L = 1'b1; ub_L = 1'b1; lb_L = 1'b1; tb_drv = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset_L = 1'b0;
        idle_bus();
        repeat (n) tick();
        reset_L = 1'b1;
        m_lat = 4; m_nowrap = 1; m_bl = 7;
    endtask

    task automatic write_bcr(input int lat, input int nowrap, input int blc);
        addr = 16'((lat << 11) | (nowrap << 3) | blc);
        ce_L = 1'b0; adv_L = 1'b0; mcre = 1'b1; we_L = 1'b0;
        tick();
        idle_bus();
        @(negedge clk);
        chk("cfg_wait", 16'(mem_wait), 16'h0000);
        tick();
        if (lat >= 2 && lat <= 6) m_lat = lat;
        m_nowrap = nowrap;
        if (blc == 1 || blc == 2 || blc == 3 || blc == 7) m_bl = blc;
    endtask

    // One burst of nbeats beats; writes take bw_data/bw_mask ({ub_L,lb_L})
    task automatic burst(input bit wr, input int start, input int nbeats, input string tag);
        int          n;
        int          a;
        bit          done_exp;
        logic [15:0] w;
        done_exp = (m_bl != 7) && (nbeats == bl_len(m_bl));
        addr = 16'(start);
        ce_L = 1'b0; adv_L = 1'b0; mcre = 1'b0;
        we_L = wr ? 1'b0 : 1'b1;
        oe_L = wr ? 1'b1 : 1'b0;
        tick();
        adv_L = 1'b1; we_L = 1'b1; addr = 16'($urandom);
        n = 0;
        @(negedge clk);
        while (mem_wait === 1'b1 && n < 12) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, 16'(n), 16'(m_lat - 1));
        for (int i = 0; i < nbeats; i++) begin
            a = beat_addr(start, i);
            if (wr) begin
                tb_dq = bw_data[i]; tb_drv = 1'b1;
                ub_L = bw_mask[i][1]; lb_L = bw_mask[i][0];
                w = mm.exists(a) ? mm[a] : 16'h0000;
                if (!bw_mask[i][1]) w[15:8] = bw_data[i][15:8];
                if (!bw_mask[i][0]) w[7:0]  = bw_data[i][7:0];
                mm[a] = w;
            end else begin
                chk({tag, "_rd"}, data, mm[a]);
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (done_exp) begin
            tb_drv = 1'b0; oe_L = 1'b0;
            #1;
            chk({tag, "_done_wait"}, 16'(mem_wait), 16'h0000);
            chk({tag, "_done_z"}, data, z16);
            if (wr) begin
                tb_dq = 16'($urandom); tb_drv = 1'b1; ub_L = 1'b0; lb_L = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (wr) begin
            tb_dq = 16'($urandom); tb_drv = 1'b1; ub_L = 1'b0; lb_L = 1'b0;
        end
        ce_L = 1'b1;
        tick();
        idle_bus();
        oe_L = 1'b0;
        @(negedge clk);
        chk({tag, "_end_wait"}, 16'(mem_wait), 16'h0000);
        chk({tag, "_end_z"}, data, z16);
        oe_L = 1'b1;
    endtask

    initial begin
        int lat;
        int wb;
        int blc;
        int start;
        int nb;

        z16 = 16'hzzzz;
        addr = 16'h0000; tb_dq = 16'h0000;
        reset_L = 1'b1;
        idle_bus();

        // Reset defaults: latency 4, continuous, over a zeroed region
        do_reset(2);
        for (int i = 0; i < 4; i++) begin bw_data[i] = 16'h0000; bw_mask[i] = 2'b00; end
        burst(1'b1, 'h0010, 4, "pre0");
        do_reset(2);
        oe_L = 1'b0;
        @(negedge clk);
        chk("rst_wait", 16'(mem_wait), 16'h0000);
        chk("rst_z", data, z16);
        oe_L = 1'b1;
        burst(1'b0, 'h0010, 4, "rst_rd");

        // Byte-lane masking: upper lane held, lower lane written
        bw_data[0] = 16'h1234; bw_mask[0] = 2'b00;
        burst(1'b1, 'h0100, 1, "mask_pre");
        bw_data[0] = 16'hBEEF; bw_mask[0] = 2'b10;
        burst(1'b1, 'h0100, 1, "mask_wr");
        burst(1'b0, 'h0100, 1, "mask_rd");

        // Continuous linear burst rolling over the top of memory
        bw_data[0] = 16'h1111; bw_data[1] = 16'h2222; bw_data[2] = 16'h3333;
        for (int i = 0; i < 3; i++) bw_mask[i] = 2'b00;
        burst(1'b1, 'hFFFE, 3, "top_wr");
        burst(1'b0, 'hFFFE, 3, "top_rd");

        // Latency 6, BL=4 wrap, start mid-block
        for (int i = 0; i < 4; i++) begin bw_data[i] = 16'hA0A0 + 16'(i * 'h0101); bw_mask[i] = 2'b00; end
        burst(1'b1, 'h0020, 4, "wrap_pre");
        write_bcr(6, 0, 1);
        burst(1'b0, 'h0022, 4, "wrap_rd");

        // BL=8 linear, early termination after two beats
        write_bcr(3, 1, 2);
        for (int i = 0; i < 8; i++) begin bw_data[i] = 16'($urandom); bw_mask[i] = 2'b00; end
        burst(1'b1, 'h0200, 8, "term_pre");
        for (int i = 0; i < 2; i++) bw_data[i] = 16'($urandom);
        burst(1'b1, 'h0200, 2, "term_wr");
        burst(1'b0, 'h0200, 8, "term_rd");

        // Illegal latency and BL code leave those fields untouched
        write_bcr(7, 1, 5);
        burst(1'b0, 'h0200, 8, "ill_rd");

        // Randomized BCR and burst sweep
        for (int it = 0; it < 6; it++) begin
            lat   = int'($urandom_range(0, 7));
            wb    = int'($urandom_range(0, 1));
            blc   = int'($urandom_range(0, 7));
            start = int'($urandom_range(0, 65535));
            write_bcr(lat, wb, blc);
            if (m_bl == 7) nb = int'($urandom_range(1, 6));
            else if ($urandom_range(0, 1) == 1) nb = bl_len(m_bl);
            else nb = int'($urandom_range(1, bl_len(m_bl)));
            for (int i = 0; i < 16; i++) begin bw_data[i] = 16'($urandom); bw_mask[i] = 2'b00; end
            burst(1'b1, start, nb, "rnd_full");
            for (int i = 0; i < 16; i++) begin bw_data[i] = 16'($urandom); bw_mask[i] = 2'($urandom); end
            burst(1'b1, start, nb, "rnd_mask");
            burst(1'b0, start, nb, "rnd_rd");
        end

        // Reset during WR_WAIT restores BCR defaults and writes nothing
        do_reset(1);
        for (int i = 0; i < 4; i++) begin bw_data[i] = 16'($urandom); bw_mask[i] = 2'b00; end
        burst(1'b1, 'h030E, 4, "mrst_pre");
        for (int i = 0; i < 2; i++) bw_data[i] = 16'($urandom);
        burst(1'b1, 'h0300, 2, "mrst_pre2");
        write_bcr(5, 0, 3);
        addr = 16'h030E; ce_L = 1'b0; adv_L = 1'b0; we_L = 1'b0;
        tick();
        adv_L = 1'b1; we_L = 1'b1;
        @(negedge clk);
        chk("mrst_in_wait", 16'(mem_wait), 16'h0001);
        reset_L = 1'b0;
        tb_dq = 16'hDEAD; tb_drv = 1'b1; ub_L = 1'b0; lb_L = 1'b0;
        tick();
        reset_L = 1'b1;
        m_lat = 4; m_nowrap = 1; m_bl = 7;
        idle_bus();
        oe_L = 1'b0;
        @(negedge clk);
        chk("mrst_wait", 16'(mem_wait), 16'h0000);
        chk("mrst_z", data, z16);
        oe_L = 1'b1;
        burst(1'b0, 'h030E, 4, "mrst_rd");
        burst(1'b0, 'h0300, 2, "mrst_rd2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
